imm_encoder: RTL and testbench

- Pipelined RISC-V RV32I instruction-word encoder; the inverse of `sign_extender`.
- Accepts an opcode, register fields and a full 32-bit immediate value, checks the immediate's range and alignment for the selected format, and scatters its bits into a 32-bit instruction word.
- Used by the self-test program generator and the boot loader to build instructions on the fly.
- Round-trip property: when `out_err=0`, `sign_extender` decoding of `out_instr` with the same `imm_src` returns exactly `in_imm`.

---
 rtl/rv32_pkg.sv | 21 ++
 rtl/imm_encoder_if.sv | 26 ++
 rtl/imm_range_check.sv | 23 ++
 rtl/imm_encoder.sv | 110 +++++++++++
 tb/tb_imm_encoder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// RV32I types and constants shared by the instruction encoder and its checkers.
package rv32_pkg;

    typedef enum logic [2:0] {
        IMM_U = 3'd0,
        IMM_I = 3'd1,
        IMM_J = 3'd2,
        IMM_S = 3'd3,
        IMM_B = 3'd4
    } imm_src_t;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -1048576;
    localparam int IMMJ_MAX  = 1048574;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result handshake bundle for imm_encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_imm_src;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_imm_src, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_imm_src, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/imm_range_check.sv
// Flags immediates that the selected RV32I format cannot represent exactly.
module imm_range_check
    import rv32_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    output logic        err
);
    logic signed [31:0] simm;

    assign simm = $signed(imm);

    always_comb begin
        err = 1'b1;
        case (imm_src_t'(imm_src))
            IMM_U:        err = (imm[11:0] != 12'd0);
            IMM_I, IMM_S: err = (simm < IMM12_MIN) || (simm > IMM12_MAX);
            IMM_B:        err = (simm < IMMB_MIN) || (simm > IMMB_MAX) || imm[0];
            IMM_J:        err = (simm < IMMJ_MIN) || (simm > IMMJ_MAX) || imm[0];
            default:      err = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction encoder: S1 captures fields and the range verdict,
// S2 holds the packed word until the consumer takes it.
module imm_encoder
    import rv32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    logic        s1_valid;
    logic [2:0]  s1_src;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [31:0] s1_imm;
    logic        s1_err;
    logic        chk_err;
    logic [31:0] packed_word;
    logic        s2_ready;
    logic        s1_adv;
    logic        in_fire;
    logic        out_fire;

    imm_range_check u_check (
        .imm_src (bus.in_imm_src),
        .imm     (bus.in_imm),
        .err     (chk_err)
    );

    // S1 may refill in the same cycle it drains, so in_ready looks through to out_ready.
    assign s2_ready     = ~bus.out_valid | bus.out_ready;
    assign s1_adv       = s1_valid & s2_ready;
    assign bus.in_ready = ~s1_valid | s2_ready;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign out_fire     = bus.out_valid & bus.out_ready;

    always_comb begin
        packed_word = NOP;
        case (imm_src_t'(s1_src))
            IMM_U: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
            IMM_I: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            IMM_S: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            IMM_B: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                  s1_imm[4:1], s1_imm[11], s1_opcode};
            IMM_J: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                  s1_rd, s1_opcode};
            default: packed_word = NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_src    <= '0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_imm    <= '0;
            s1_err    <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_src    <= bus.in_imm_src;
                s1_opcode <= bus.in_opcode;
                s1_rd     <= bus.in_rd;
                s1_rs1    <= bus.in_rs1;
                s1_rs2    <= bus.in_rs2;
                s1_funct3 <= bus.in_funct3;
                s1_imm    <= bus.in_imm;
                s1_err    <= chk_err;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_err   <= 1'b0;
        end else if (s1_adv) begin
            bus.out_valid <= 1'b1;
            bus.out_instr <= packed_word;
            bus.out_err   <= s1_err;
        end else if (out_fire) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (in_fire && (enc_count != '1))
                enc_count <= enc_count + CNT_W'(1);
            if (out_fire && bus.out_err && (err_count != '1))
                err_count <= err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: placement, range errors, backpressure, reset, saturation, round trip.
module tb_imm_encoder;
    import rv32_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_encoder_if bus ();
    imm_encoder_if sbus ();
    logic [15:0] enc_count, err_count;
    logic [3:0]  s_enc, s_err;

    imm_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    imm_encoder #(.CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (sbus),
        .enc_count (s_enc),
        .err_count (s_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [31:0] imm);
        bus.in_valid   = 1'b1;
        bus.in_imm_src = src;
        bus.in_opcode  = op;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_funct3  = f3;
        bus.in_imm     = imm;
    endtask

    // One request end to end; lat counts edges from (and including) the accepting edge.
    task automatic xfer(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] imm, output logic [31:0] instr, output logic err,
                        output int lat);
        int guard;
        bus.out_ready = 1'b1;
        drive(src, op, rd, rs1, rs2, f3, imm);
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 20) check("out_timeout", {31'd0, bus.out_valid}, 32'd1);
        instr = bus.out_instr;
        err   = bus.out_err;
        @(posedge clk); #1;
    endtask

    // Reference immediate decoder, independent of the RTL packing.
    function automatic logic [31:0] decode(input logic [2:0] src, input logic [31:0] w);
        case (src)
            3'd0:    decode = {w[31:12], 12'b0};
            3'd1:    decode = {{20{w[31]}}, w[31:20]};
            3'd3:    decode = {{20{w[31]}}, w[31:25], w[11:7]};
            3'd4:    decode = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd2:    decode = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: decode = '0;
        endcase
    endfunction

    logic [2:0]  v_src [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [6:0]  v_op  [4] = '{7'h13, 7'h6F, 7'h23, 7'h63};
    logic [4:0]  v_rd  [4] = '{5'd1, 5'd0, 5'd0, 5'd0};
    logic [4:0]  v_rs1 [4] = '{5'd2, 5'd0, 5'd2, 5'd1};
    logic [4:0]  v_rs2 [4] = '{5'd0, 5'd0, 5'd1, 5'd2};
    logic [2:0]  v_f3  [4] = '{3'd0, 3'd0, 3'd2, 3'd1};
    logic [31:0] v_imm [4] = '{32'd1000, 32'd1000, 32'd1000, 32'd12};
    logic [31:0] v_exp [4] = '{32'h3E810093, 32'h3E80006F, 32'h3E112423, 32'h00209663};

    logic [2:0]  b_src [13] = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4,
                                3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
    logic [31:0] b_imm [13] = '{32'hFFFFF800, 32'd2047, 32'hFFFFF7FF, 32'd2048,
                                32'd4094, 32'hFFFFF000, 32'd4096, 32'hFFFFEFFE,
                                32'd1048574, 32'hFFF00000, 32'd1048576, 32'd3, 32'hFFFFF000};
    logic        b_err [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] instr;
        logic        err;
        int          lat;
        int          idx;
        int          seen;
        logic        acc;
        logic [31:0] got[$];
        logic [31:0] rimm;
        logic [2:0]  rsrc;

        bus.in_valid = 1'b0;  bus.in_imm_src = '0; bus.in_opcode = '0; bus.in_rd = '0;
        bus.in_rs1 = '0;      bus.in_rs2 = '0;     bus.in_funct3 = '0;  bus.in_imm = '0;
        bus.out_ready = 1'b1;
        sbus.in_valid = 1'b0; sbus.in_imm_src = 3'd1; sbus.in_opcode = 7'h13; sbus.in_rd = 5'd1;
        sbus.in_rs1 = '0;     sbus.in_rs2 = '0;       sbus.in_funct3 = '0;    sbus.in_imm = '0;
        sbus.out_ready = 1'b1;

        #12;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_instr", bus.out_instr,          32'd0);
        check("rst_out_err",   {31'd0, bus.out_err},   32'd0);
        check("rst_enc_count", {16'd0, enc_count},     32'd0);
        check("rst_err_count", {16'd0, err_count},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(3'd0, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h003E8000, instr, err, lat);
        check("lui_instr", instr, 32'h003E80B7);
        check("lui_err", {31'd0, err}, 32'd0);
        check("lui_latency", lat, 32'd2);

        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(v_src[k], v_op[k], v_rd[k], v_rs1[k], v_rs2[k], v_f3[k], v_imm[k]);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (k < 4) check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk); #1;
            if (k == 0) begin
                check("stream_first_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stream_instr", bus.out_instr, v_exp[k-1]);
                check("stream_err", {31'd0, bus.out_err}, 32'd0);
            end
        end
        @(posedge clk); #1;

        xfer(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048, instr, err, lat);
        check("err_i_instr", instr, 32'h80010093);
        check("err_i_flag", {31'd0, err}, 32'd1);
        xfer(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 32'd13, instr, err, lat);
        check("err_b_instr", instr, 32'h00209663);
        check("err_b_flag", {31'd0, err}, 32'd1);
        xfer(3'd0, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00001234, instr, err, lat);
        check("err_u_instr", instr, 32'h000010B7);
        check("err_u_flag", {31'd0, err}, 32'd1);
        xfer(3'd6, 7'h33, 5'd3, 5'd4, 5'd5, 3'd7, 32'd0, instr, err, lat);
        check("err_src_nop", instr, 32'h00000013);
        check("err_src_flag", {31'd0, err}, 32'd1);
        check("err_count_4", {16'd0, err_count}, 32'd4);
        check("enc_count_9", {16'd0, enc_count}, 32'd9);

        bus.out_ready = 1'b0;
        idx = 0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        for (int c = 0; c < 12; c++) begin
            if (c == 5) bus.out_ready = 1'b1;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_instr);
            if (c >= 2 && c < 5) begin
                check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                check("bp_hold_instr", bus.out_instr, 32'h00100093);
            end
            if (c == 4) check("bp_accepts", idx, 32'd2);
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, idx + 1);
                else bus.in_valid = 1'b0;
            end
        end
        check("bp_count", got.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            check("bp_order", (i < got.size()) ? got[i] : 32'hXXXXXXXX, {12'h001 + 12'(i), 20'h00093} >> 0 == 0 ? 32'd0 : ((32'(i) + 32'd1) << 20) | 32'h93);
        check("bp_enc_count", {16'd0, enc_count}, 32'd12);

        bus.out_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        @(posedge clk); #1;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd6);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("mid_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_enc", {16'd0, enc_count}, 32'd0);
        check("mid_rst_err", {16'd0, err_count}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("mid_no_emit", seen, 32'd0);

        sbus.in_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
        check("sat_enc_count", {28'd0, s_enc}, 32'd15);
        check("sat_err_count", {28'd0, s_err}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            xfer(b_src[i], 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, b_imm[i], instr, err, lat);
            check("bound_err", {31'd0, err}, {31'd0, b_err[i]});
            if (!b_err[i]) check("bound_decode", decode(b_src[i], instr), b_imm[i]);
        end

        for (int s = 0; s < 5; s++) begin
            for (int n = 0; n < 6; n++) begin
                rsrc = 3'(s);
                case (s)
                    0:       rimm = $urandom & 32'hFFFFF000;
                    1, 3:    rimm = 32'(int'($urandom_range(4095, 0)) - 2048);
                    4:       rimm = 32'((int'($urandom_range(4095, 0)) - 2048) * 2);
                    default: rimm = 32'((int'($urandom_range(1048575, 0)) - 524288) * 2);
                endcase
                xfer(rsrc, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                     rimm, instr, err, lat);
                check("rt_err", {31'd0, err}, 32'd0);
                check("rt_decode", decode(rsrc, instr), rimm);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
